// File: rtl/dice_roll_sequencer.sv
// Sequences a single shared dice_roller to roll N dice of one type and returns the
// total, optionally minus the lowest die, over valid/ready request/result handshakes.
module dice_roll_sequencer #(
    parameter int MAX_DICE = 8,
    parameter int CNT_W    = 4,
    parameter int SUM_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [1:0]       req_die,
    input  logic             req_drop_lowest,
    output logic             roll_o,
    output logic [1:0]       die_select_o,
    input  logic [7:0]       rolled_number_i,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic             res_err
);

    typedef enum logic [1:0] {IDLE, ROLL, CAPTURE, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DICE);

    state_t           state_reg;
    logic [CNT_W-1:0] remain_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [7:0]       min_reg;
    logic             err_reg;
    logic             drop_lowest_reg;

    logic [3:0]       in_range;
    logic             value_ok;
    logic [SUM_W-1:0] rolled_ext;
    logic [SUM_W-1:0] sum_next;
    logic [7:0]       min_next;
    logic             err_next;

    // One range comparator per die type; the latched die picks the relevant one.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_range
            localparam logic [7:0] FACES = (gi == 0) ? 8'd4 :
                                           (gi == 1) ? 8'd6 :
                                           (gi == 2) ? 8'd8 : 8'd20;
            assign in_range[gi] = (rolled_number_i != 8'd0) && (rolled_number_i <= FACES);
        end
    endgenerate

    assign value_ok   = in_range[die_select_o];
    assign rolled_ext = SUM_W'(rolled_number_i);
    assign sum_next   = sum_reg + rolled_ext;
    assign min_next   = (rolled_number_i < min_reg) ? rolled_number_i : min_reg;
    assign err_next   = err_reg | ~value_ok;
    assign req_ready  = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            remain_reg      <= '0;
            sum_reg         <= '0;
            min_reg         <= 8'hFF;
            err_reg         <= 1'b0;
            drop_lowest_reg <= 1'b0;
            roll_o          <= 1'b0;
            die_select_o    <= 2'b00;
            res_valid       <= 1'b0;
            res_sum         <= '0;
            res_err         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        drop_lowest_reg <= req_drop_lowest;
                        die_select_o    <= req_die;
                        sum_reg         <= '0;
                        min_reg         <= 8'hFF;
                        if (req_count == '0) begin
                            err_reg   <= 1'b0;
                            res_sum   <= '0;
                            res_err   <= 1'b0;
                            res_valid <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            remain_reg <= (req_count > MAX_CNT) ? MAX_CNT : req_count;
                            err_reg    <= (req_count > MAX_CNT);
                            roll_o     <= 1'b1;
                            state_reg  <= ROLL;
                        end
                    end
                end
                ROLL: begin
                    roll_o    <= 1'b0;
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    // The roller updated on the edge that ended ROLL, so its output is valid now.
                    sum_reg    <= sum_next;
                    min_reg    <= min_next;
                    err_reg    <= err_next;
                    remain_reg <= remain_reg - CNT_W'(1);
                    if (remain_reg == CNT_W'(1)) begin
                        res_sum   <= sum_next - (drop_lowest_reg ? SUM_W'(min_next) : '0);
                        res_err   <= err_next;
                        res_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        roll_o    <= 1'b1;
                        state_reg <= ROLL;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dice_roll_sequencer.md
Name: dice_roll_sequencer

Overview:
- Controller that sequences one shared dice_roller datapath to roll N dice of one type and return the total.
- Accepts a roll request (count, die type, drop-lowest option) over a valid/ready handshake.
- Pulses the roller once per die, captures each rolled value, and accumulates sum and minimum.
- Presents the total, optionally minus the lowest die, over a valid/ready result handshake.
- Sits between game/control logic and a single dice_roller instance.

Parameters:
- MAX_DICE, 8, largest accepted dice count. Legal range 1..15.
- CNT_W, 4, width of the count field.
- SUM_W, 9, width of the accumulated sum. Must hold MAX_DICE*20.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_count  input  CNT_W  number of dice to roll
- req_die  input  2  die type: 00=d4, 01=d6, 10=d8, 11=d20
- req_drop_lowest  input  1  subtract the minimum die from the total
- roll_o  output  1  roll strobe to the dice_roller
- die_select_o  output  2  die type to the dice_roller
- rolled_number_i  input  8  roller output
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- res_sum  output  SUM_W  final total
- res_err  output  1  one or more captured values were out of range, or count was clamped

Behaviour:
- Reset is asynchronous on rst_n low:
  - state goes to IDLE immediately; roll_o=0; res_valid=0.
  - res_sum=0; res_err=0; die_select_o=00; internal sum, min and counter cleared.
  - Reset mid-sequence aborts the sequence with no result.
  - req_ready=1 in the first cycle after rst_n deasserts.
- States: IDLE, ROLL, CAPTURE, DONE. req_ready=1 only in IDLE.
- IDLE:
  - On the edge where req_valid & req_ready are both high, latch count, die and drop_lowest.
  - Set sum=0, min=8'hFF, err=0.
  - Count 0: go to DONE with sum 0 and no roll pulses.
  - Count > MAX_DICE: clamp to MAX_DICE, set err=1.
  - Otherwise go to ROLL.
- ROLL (exactly 1 cycle):
  - roll_o=1 and die_select_o=latched die.
  - Always go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - roll_o=0. The roller has updated on the previous edge, so rolled_number_i is sampled here.
  - sum += rolled_number_i, zero-extended to SUM_W.
  - min = min(min, rolled_number_i).
  - Decrement the remaining count.
  - If the value is outside 1..faces (faces = 4/6/8/20), set err=1; the value is still added.
  - Remaining count becomes 0: go to DONE. Otherwise go to ROLL.
- roll_o is never high in two consecutive cycles. die_select_o is stable from ROLL through CAPTURE.
- Latency: the first ROLL cycle immediately follows the accept edge. For N≥1, res_valid rises in cycle 2N+1 after the accept edge. For N=0, res_valid rises in the cycle after the accept edge.
- DONE:
  - res_valid=1.
  - res_sum = sum − (drop_lowest && N≥1 ? min : 0). For N=1 with drop, the result is 0.
  - N=0 with drop: no subtraction, res_sum=0.
  - res_sum and res_err are stable while res_valid=1 and res_ready=0.
  - On the res_valid & res_ready edge, go to IDLE; res_valid drops next cycle; res_sum holds its last value.
- Back-to-back requests: a new request is accepted no earlier than the cycle after the result handshake. req_valid during busy states is ignored, not queued.
- Sum arithmetic never wraps within legal parameters; no saturation logic.

Test Plan:
- Reset values:
  - Stimulus: assert rst_n low mid-ROLL.
  - Required: roll_o=0 immediately; res_valid=0; req_ready=1 after release; the next request completes normally.
- 3×d6, no drop:
  - Stimulus: stub returns 4, 1, 6.
  - Required: exactly three single-cycle roll_o pulses with die_select_o=01; res_valid at cycle 7 after accept; res_sum=11; res_err=0.
- 4×d6 with drop_lowest:
  - Stimulus: stub returns 5, 2, 6, 3.
  - Required: res_sum=14; with res_ready held low for 5 cycles, res_sum stays 14 and res_valid stays high.
- Count 0:
  - Stimulus: request count 0.
  - Required: no roll_o pulse; res_valid the next cycle; res_sum=0.
  - Stimulus: request count 1 with drop.
  - Required: res_sum=0.
- Range and clamp errors:
  - Stimulus: 2×d4, stub returns 5 then 2.
  - Required: res_sum=7, res_err=1.
  - Stimulus: count 12 with MAX_DICE=8.
  - Required: 8 roll pulses, res_err=1.
- Busy and back-to-back:
  - Stimulus: hold req_valid high throughout.
  - Required: req_ready low during the sequence; the second request is accepted only after the res handshake; the two results are returned in order.
